// File: rtl/mem_access_unit.sv
// Byte-addressed 8/16/32-bit load/store front end for a word-addressed single-port SRAM.
// Define MEM_BOUNDS_CHECK_EN to reject requests that target unmapped word addresses.
module mem_access_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_enw,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;
    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;
    localparam logic [1:0]  SZ_BAD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;

    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;
    logic [WIDTH-1:0] mem_address_q, mem_address_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic             mem_enw_q, mem_enw_d;

    logic [WIDTH-1:0] req_word;
    logic             req_misalign;
    logic             req_oob;
    logic             req_err;

    // Little-endian lane extract with sign/zero extension.
    function automatic logic [WIDTH-1:0] lane_load(input logic [WIDTH-1:0] word,
                                                   input logic [1:0]       size,
                                                   input logic [1:0]       off,
                                                   input logic             uns);
        logic [BYTE_W-1:0] b;
        logic [HALF_W-1:0] h;
        b = BYTE_W'(word >> {off, 3'b000});
        h = HALF_W'(word >> {off[1], 4'b0000});
        case (size)
            SZ_BYTE: lane_load = {{(WIDTH-BYTE_W){b[BYTE_W-1] & ~uns}}, b};
            SZ_HALF: lane_load = {{(WIDTH-HALF_W){h[HALF_W-1] & ~uns}}, h};
            default: lane_load = word;
        endcase
    endfunction

    // Replace the addressed lane of the captured word with the store data.
    function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0] word,
                                                    input logic [WIDTH-1:0] wd,
                                                    input logic [1:0]       size,
                                                    input logic [1:0]       off);
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] ins;
        mask = '1;
        ins  = wd;
        case (size)
            SZ_BYTE: begin
                mask = WIDTH'({BYTE_W{1'b1}}) << {off, 3'b000};
                ins  = WIDTH'(wd[BYTE_W-1:0]) << {off, 3'b000};
            end
            SZ_HALF: begin
                mask = WIDTH'({HALF_W{1'b1}}) << {off[1], 4'b0000};
                ins  = WIDTH'(wd[HALF_W-1:0]) << {off[1], 4'b0000};
            end
            default: ;
        endcase
        lane_merge = (word & ~mask) | (ins & mask);
    endfunction

    assign req_word     = req_addr >> 2;
    assign req_misalign = ((req_size == SZ_HALF) && req_addr[0])
                        || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

`ifdef MEM_BOUNDS_CHECK_EN
    localparam int unsigned HOLE_LO = 1537;
    localparam int unsigned HOLE_HI = 1999;
    localparam int unsigned TOP_MAX = 3024;
    assign req_oob = ((req_word >= WIDTH'(HOLE_LO)) && (req_word <= WIDTH'(HOLE_HI)))
                   || (req_word > WIDTH'(TOP_MAX));
`else
    assign req_oob = 1'b0;
`endif

    assign req_err = (req_size == SZ_BAD) || req_misalign || req_oob;

    // Next state, request capture and next values of the registered outputs.
    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        size_d        = size_q;
        uns_d         = uns_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = '0;
        resp_err_d    = 1'b0;
        mem_address_d = '0;
        mem_wdata_d   = '0;
        mem_enw_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_err) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_d       = S_WRITE;
                        mem_address_d = req_word;
                        mem_wdata_d   = req_wdata;
                        mem_enw_d     = 1'b1;
                    end else begin
                        state_d       = S_READ;
                        mem_address_d = req_word;
                    end
                end
            end
            S_READ: begin
                if (we_q) begin
                    state_d       = S_WRITE;
                    mem_address_d = addr_q >> 2;
                    mem_wdata_d   = lane_merge(mem_rdata, wdata_q, size_q, addr_q[1:0]);
                    mem_enw_d     = 1'b1;
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = lane_load(mem_rdata, size_q, addr_q[1:0], uns_q);
                end
            end
            S_WRITE: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    // Async reset clears mem_enw at once, so an aborted sub-word store never writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            we_q          <= 1'b0;
            size_q        <= 2'b00;
            uns_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
            resp_err_q    <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_enw_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            size_q        <= size_d;
            uns_q         <= uns_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_enw_q     <= mem_enw_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_enw     = mem_enw_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end between the CPU load/store stage and the word-addressed single-port SRAM. Accepts byte-addressed 8/16/32-bit load and store requests over a ready/valid handshake. Converts them to word accesses, with read-modify-write for sub-word stores and lane extract plus sign/zero extension for loads. Returns one response per request and flags misaligned accesses.

## Interface
- WIDTH, 32, data and address width; only 32 is supported.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- req_valid  in  1  request present.
- req_ready  out  1  high exactly when state is IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal (error).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  WIDTH  byte address.
- req_wdata  in  WIDTH  store data, right-aligned.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  WIDTH  load result; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid.
- mem_address  out  WIDTH  word address to SRAM, equal to req_addr >> 2.
- mem_wdata  out  WIDTH  full word to SRAM.
- mem_enw  out  1  SRAM write enable.
- mem_rdata  in  WIDTH  SRAM read data, combinational from mem_address.

## Operation
- States: IDLE, READ, WRITE, RESP.
- In IDLE, req_valid high registers req_we, req_size, req_unsigned, req_addr and req_wdata. Next state:
  - error → RESP;
  - load → READ;
  - word store → WRITE;
  - byte or halfword store → READ.
- Error conditions, checked at acceptance:
  - req_size = 11;
  - halfword with addr[0] = 1;
  - word with addr[1:0] ≠ 0.
- READ:
  - mem_address is driven and mem_rdata is captured into a word register.
  - A load computes its result from the register and goes to RESP. A sub-word store goes to WRITE.
- Lane selection is little-endian. A byte uses lane addr[1:0], i.e. bits 8·k+7 : 8·k. A halfword uses lane addr[1], i.e. bits 16·h+15 : 16·h.
- Loads extend by req_unsigned: zero-extend when 1, sign-extend from the lane MSB when 0.
- WRITE:
  - mem_enw = 1 for exactly one cycle.
  - Word store: mem_wdata = req_wdata.
  - Sub-word store: mem_wdata = captured word with the selected lane replaced by req_wdata[7:0] or req_wdata[15:0]; all other lanes unchanged.
  - Next state is RESP.
- RESP: resp_valid = 1 for one cycle, resp_err and resp_rdata valid, then IDLE.
- Upstream must accept the response in the RESP cycle; no backpressure on the response.
- Outside READ and WRITE: mem_address = 0, mem_wdata = 0, mem_enw = 0. mem_enw is never asserted for an error request.
- Outside RESP: resp_rdata = 0 and resp_err = 0.

## Timing
- Request accepted in cycle N, when req_valid and req_ready are both high in IDLE.
- Load: READ at N+1, resp_valid at N+2.
- Word store: write at N+1, resp_valid at N+2.
- Sub-word store: READ at N+1, write at N+2, resp_valid at N+3.
- Error: resp_valid at N+1; no memory cycle.
- req_ready drops the cycle after acceptance and returns in the cycle after RESP. Back-to-back throughput is therefore one request per 3 cycles for loads and word stores, and 4 for sub-word stores.
- Reset values: state IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_address = 0, mem_wdata = 0, mem_enw = 0.
- Reset mid-operation aborts immediately. mem_enw falls asynchronously with rst, so no partial write completes after assertion, and no response is issued.
- req_valid is ignored while rst is high.

## Configuration
- MEM_BOUNDS_CHECK_EN defined: a word address in 1537..1999 or above 3024 is an error. The request goes to RESP with resp_err = 1 and no SRAM access.
- MEM_BOUNDS_CHECK_EN undefined: no range check. Unmapped reads return whatever the SRAM drives (0), and unmapped writes are passed through.

## Test plan
- Word store 0x8899AABB to byte address 5200, then word load from 5200 → resp_rdata = 0x8899AABB, resp_err = 0. Response 2 cycles after each acceptance.
- Signed byte load from 5201 → 0xFFFFFFAA. Unsigned byte load from 5201 → 0x000000AA.
- Byte store 0x5C to 5202 → exactly one mem_enw pulse at N+2 with mem_address = 1300 and mem_wdata = 0x885CAABB. A following unsigned halfword load from 5202 → 0x0000885C.
- Misaligned word load from 5201, misaligned halfword store to 5203, and req_size = 11 → resp_err = 1 at N+1, resp_rdata = 0, mem_enw never high.
- With MEM_BOUNDS_CHECK_EN defined, word store to byte address 6400 (word 1600) → resp_err = 1 and no write. Without the macro → mem_enw pulses with mem_address = 1600.
- Assert rst in the READ cycle of a sub-word store → mem_enw stays 0, no resp_valid, all outputs at reset values. The word at the target address is unchanged.
